imem_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous memory (1-cycle read latency) between the instruction-fetch port and the data load/store port of the core.
- Serves one request per cycle.
- Data port has fixed priority. A saturating starvation counter forces a fetch grant after MAX_WAIT consecutive denials.
- Sits between the fetch/LSU stages and the unified memory macro, replacing the separate combinational instruction store.

---
 rtl/mem_arb_pkg.sv | 5 +
 rtl/mem_sync_model.sv | 21 ++
 rtl/imem_dmem_arbiter.sv | 56 +++++
 tb/tb_imem_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D_RD, OWN_D_WR} rsp_owner_e;
    localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/mem_sync_model.sv
// mem_sync_model: word-indexed single-port memory with byte writes and 1-cycle read latency
module mem_sync_model #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en && !we) rdata <= mem[addr];
        for (int b = 0; b < DATA_W/8; b++)
            if (en && we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one synchronous memory between fetch and data ports, data priority with starvation guard
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    logic [WAIT_CNT_W-1:0] wait_cnt;
    rsp_owner_e rsp_owner, nxt_owner;
    logic force_if, grant_if, grant_d;
    always_comb begin
        force_if = wait_cnt == WAIT_CNT_W'(MAX_WAIT);
        grant_if = !rst && if_req_valid && (!d_req_valid || force_if);
        grant_d = !rst && d_req_valid && !grant_if;
        if_req_ready = grant_if;
        d_req_ready = grant_d;
        mem_en = grant_if || grant_d;
        mem_we = grant_d && d_req_we;
        mem_be = mem_we ? d_req_be : mem_en ? '1 : '0;
        mem_addr = grant_d ? d_req_addr : grant_if ? if_req_addr : '0;
        mem_wdata = mem_we ? d_req_wdata : '0;
        nxt_owner = grant_if ? OWN_IF : grant_d ? (d_req_we ? OWN_D_WR : OWN_D_RD) : OWN_NONE;
        if_rsp_valid = !rst && rsp_owner == OWN_IF;
        if_rsp_data = if_rsp_valid ? mem_rdata : '0;
        d_rsp_valid = !rst && (rsp_owner == OWN_D_RD || rsp_owner == OWN_D_WR);
        d_rsp_rdata = (!rst && rsp_owner == OWN_D_RD) ? mem_rdata : '0;
    end
    always_ff @(posedge clk) begin
        rsp_owner <= rst ? OWN_NONE : nxt_owner;
        wait_cnt <= (rst || !if_req_valid || grant_if) ? '0 :
                    force_if ? wait_cnt : wait_cnt + WAIT_CNT_W'(1);
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed self-checking bench for imem_dmem_arbiter with a synchronous memory model
module tb_imem_dmem_arbiter;
    logic clk = 0, rst = 1;
    logic if_req_valid = 0, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr = 0, if_rsp_data;
    logic d_req_valid = 0, d_req_ready, d_req_we = 0, d_rsp_valid;
    logic [31:0] d_req_addr = 0, d_req_wdata = 0, d_rsp_rdata;
    logic [3:0] d_req_be = 0, mem_be;
    logic mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int checks = 0, errors = 0;
    logic [31:0] words [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_sync_model #(.DATA_W(32), .DEPTH(64)) u_mem (
        .clk(clk), .en(mem_en), .we(mem_we), .be(mem_be), .addr(mem_addr[7:2]),
        .wdata(mem_wdata), .rdata(mem_rdata)
    );

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
        @(negedge clk);
        if_req_valid = iv; if_req_addr = ia;
        d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd; d_req_be = dbe;
    endtask

    task automatic test_reset;
        rst = 1;
        drive(1, 32'h10, 1, 1, 32'h20, 32'h1234, 4'hF);
        #1;
        checks++;
        if ({if_req_ready, d_req_ready, mem_en, mem_we} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {if_req_ready, d_req_ready, mem_en, mem_we});
        end
        checks++;
        if ({mem_addr, mem_be, mem_wdata} !== 68'b0) begin
            errors++; $display("FAIL reset_mem_bus: addr %h be %h wdata %h want all 0", mem_addr, mem_be, mem_wdata);
        end
        checks++;
        if ({if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_rdata} !== 66'b0) begin
            errors++; $display("FAIL reset_rsp: ifv %b dv %b ifd %h dd %h want 0", if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_rdata);
        end
        checks++;
        if (dut.wait_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.wait_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 0;
    endtask

    task automatic test_fetch;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 32'(4 * i), words[i], 4'hF);
            #1;
            checks++;
            if ({d_req_ready, mem_we, mem_be} !== 6'b111111) begin
                errors++; $display("FAIL preload_store%0d: ready/we/be %b want 111111", i, {d_req_ready, mem_we, mem_be});
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(4 * i), 0, 0, 0, 0, 0);
            #1;
            checks++;
            if ({if_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {3'b110, 4'hF, 32'(4 * i), 32'h0}) begin
                errors++; $display("FAIL fetch_grant%0d: ready %b en %b we %b be %h addr %h wdata %h", i, if_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
            end
            checks++;
            if (i == 0 && {d_rsp_valid, d_rsp_rdata, if_rsp_valid} !== {1'b1, 32'h0, 1'b0}) begin
                errors++; $display("FAIL store_ack: dv %b dd %h ifv %b want 1 0 0", d_rsp_valid, d_rsp_rdata, if_rsp_valid);
            end else if (i > 0 && {if_rsp_valid, if_rsp_data, d_rsp_valid} !== {1'b1, words[i-1], 1'b0}) begin
                errors++; $display("FAIL fetch_rsp%0d: ifv %b data %h dv %b want 1 %h 0", i - 1, if_rsp_valid, if_rsp_data, d_rsp_valid, words[i-1]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({if_rsp_valid, if_rsp_data, mem_en} !== {1'b1, words[3], 1'b0}) begin
            errors++; $display("FAIL fetch_rsp3: ifv %b data %h en %b want 1 %h 0", if_rsp_valid, if_rsp_data, mem_en, words[3]);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({if_rsp_valid, if_rsp_data} !== 33'b0) begin
            errors++; $display("FAIL fetch_after: ifv %b data %h want 0", if_rsp_valid, if_rsp_data);
        end
    endtask

    task automatic test_store_load;
        drive(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF);
        #1;
        checks++;
        if ({d_req_ready, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'hDEADBEEF}) begin
            errors++; $display("FAIL store_drive: ready %b we %b addr %h wdata %h", d_req_ready, mem_we, mem_addr, mem_wdata);
        end
        drive(0, 0, 1, 0, 32'h40, 32'h0, 4'h0);
        #1;
        checks++;
        if ({d_rsp_valid, d_rsp_rdata} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL store_ack40: dv %b dd %h want 1 0", d_rsp_valid, d_rsp_rdata);
        end
        checks++;
        if ({d_req_ready, mem_we, mem_be, mem_wdata} !== {2'b10, 4'hF, 32'h0}) begin
            errors++; $display("FAIL load_drive: ready %b we %b be %h wdata %h", d_req_ready, mem_we, mem_be, mem_wdata);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({d_rsp_valid, d_rsp_rdata, if_rsp_valid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL load40: dv %b dd %h ifv %b want 1 deadbeef 0", d_rsp_valid, d_rsp_rdata, if_rsp_valid);
        end
    endtask

    task automatic test_byte_store;
        drive(0, 0, 1, 1, 32'h44, 32'h11223344, 4'hF);
        drive(0, 0, 1, 1, 32'h44, 32'h0000AA00, 4'b0010);
        #1;
        checks++;
        if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b0010, 32'h0000AA00}) begin
            errors++; $display("FAIL byte_store_drive: we %b be %b wdata %h", mem_we, mem_be, mem_wdata);
        end
        drive(0, 0, 1, 0, 32'h44, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({d_rsp_valid, d_rsp_rdata} !== {1'b1, 32'h1122AA44}) begin
            errors++; $display("FAIL byte_store_load: dv %b dd %h want 1 1122aa44", d_rsp_valid, d_rsp_rdata);
        end
    endtask

    task automatic test_contention;
        int w = 0;
        logic prev_if = 0;
        for (int i = 0; i < 10; i++) begin
            logic exp_if;
            drive(1, 32'h0, 1, 0, 32'h40, 0, 0);
            #1;
            exp_if = (w == 4);
            checks++;
            if (dut.wait_cnt !== 4'(w)) begin
                errors++; $display("FAIL contend_wait%0d: got %0d want %0d", i, dut.wait_cnt, w);
            end
            checks++;
            if ({if_req_ready, d_req_ready, mem_addr} !== {exp_if, !exp_if, exp_if ? 32'h0 : 32'h40}) begin
                errors++; $display("FAIL contend_grant%0d: if %b d %b addr %h want if %b", i, if_req_ready, d_req_ready, mem_addr, exp_if);
            end
            if (i > 0) begin
                checks++;
                if ({if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_rdata} !==
                    (prev_if ? {2'b10, words[0], 32'h0} : {2'b01, 32'h0, 32'hDEADBEEF})) begin
                    errors++; $display("FAIL contend_rsp%0d: ifv %b dv %b ifd %h dd %h prev_if %b", i, if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_rdata, prev_if);
                end
            end
            prev_if = exp_if;
            w = exp_if ? 0 : w + 1;
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({if_rsp_valid, if_rsp_data, d_rsp_valid, dut.wait_cnt} !== {1'b1, words[0], 1'b0, 4'(w)}) begin
            errors++; $display("FAIL contend_last: ifv %b ifd %h dv %b wait %0d want 1 %h 0 %0d", if_rsp_valid, if_rsp_data, d_rsp_valid, dut.wait_cnt, words[0], w);
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h8, 0, 1, 32'h40, 32'hFFFF, 4'hF);
            #1;
            checks++;
            if ({mem_en, mem_we, if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready} !== 6'b0) begin
                errors++; $display("FAIL idle%0d: en %b we %b ifv %b dv %b ready %b%b", i, mem_en, mem_we, if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready);
            end
        end
    endtask

    task automatic test_reset_midop;
        drive(1, 32'h4, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin
            errors++; $display("FAIL midop_grant: got %b want 1", if_req_ready);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        #1;
        checks++;
        if ({if_rsp_valid, if_rsp_data} !== 33'b0) begin
            errors++; $display("FAIL midop_suppress: ifv %b data %h want 0", if_rsp_valid, if_rsp_data);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_rdata, mem_en, if_req_ready, d_req_ready} !== 69'b0) begin
                errors++; $display("FAIL midop_after%0d: ifv %b dv %b ifd %h dd %h en %b", i, if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_rdata, mem_en);
            end
            drive(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_fetch;
        test_store_load;
        test_byte_store;
        test_contention;
        test_idle;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
